bp_nonsynth_stall_accumulator: RTL and testbench
================================================

Name: bp_nonsynth_stall_accumulator

Overview:
- Non-synthesizable profiling block that sits directly downstream of the per-core stall profiler.
- Consumes one classified event per cycle: a commit, or a bubble carrying a 16-bit stall-reason vector.
- Attributes each bubble to exactly one reason by fixed priority and accumulates saturating counters.
- On request, snapshots all counters and serializes them through a valid/ready port to the testbench dump logic.

Parameters:
ctr_width_p, 32, width of every counter and of count_o
clear_on_dump_p, 1, 1 = live counters clear when a snapshot is taken; 0 = counters keep running
num_reasons_p, 16, width of the stall-reason vector (fixed at 16; other values unsupported)

Ports:
clk_i  in  1  clock
reset_li  in  1  reset, asynchronous, active-low
count_en_i  in  1  counting enable; low during freeze, nothing is counted
commit_v_i  in  1  an instruction committed this cycle
stall_reason_i  in  16  stall-reason bits; bit15 fe_queue_stall, bit14 fe_wait_stall, bit13 itlb_miss, bit12 icache_miss, bit11 icache_fence, bit10 branch_override, bit9 fe_cmd, bit8 cmd_fence, bit7 branch_mispredict, bit6 dependency_stall, bit5 dtlb_miss, bit4 dcache_miss, bit3 eret, bit2 exception, bit1 interrupt, bit0 freeze
dump_i  in  1  single-cycle snapshot request
busy_o  out  1  snapshot being serialized
v_o  out  1  readout entry valid
id_o  out  5  entry index
count_o  out  ctr_width_p  entry value
ready_i  in  1  consumer accepts the entry

Behaviour:
- Async reset (reset_li=0): all live counters, shadow registers and the entry index are 0; FSM is IDLE; busy_o=0, v_o=0, id_o=0, count_o=0.
- Live counters: reason[0..15], commit (id16), unattributed bubble (id17), total cycles (id18). 19 entries in total.
- Per-cycle update when count_en_i=1. All updates are registered and visible on the next edge.
  - cycles increments every cycle.
  - If commit_v_i=1, commit increments and stall_reason_i is ignored.
  - Else if stall_reason_i is nonzero, only the lowest-index set bit's counter increments (freeze highest priority, fe_queue_stall lowest).
  - Else unattributed increments.
- count_en_i=0: no counter changes.
- Saturation: every counter holds at 2^ctr_width_p-1 and never wraps.
- FSM states are IDLE and SEND.
- IDLE to SEND on dump_i=1:
  - Shadow[k] takes live[k] as it was before this cycle's update.
  - If clear_on_dump_p=1, live[k] takes 0 plus this cycle's increment (if any), so no event is lost or double counted.
  - Entry index is set to 0.
- SEND:
  - busy_o=1, v_o=1, id_o=index, count_o=shadow[index].
  - On v_o&ready_i the index increments.
  - On handshake with index=18, go to IDLE; v_o drops the next cycle.
  - id_o and count_o are stable while v_o=1 and ready_i=0.
- dump_i in SEND is ignored; no queuing.
- Live counting continues during SEND, independent of readout.
- Reset asserted mid-SEND: immediate abort to IDLE with the reset values above; no partial entries resume.

Test Plan:
- Reset, count_en_i=1, 10 cycles commit_v_i=1 and stall_reason_i=16'h0010, then dump_i with ready_i=1 -> 19 entries on consecutive cycles with ids 0..18; id16=10, id4=0, id18=10, all other entries 0.
- 5 cycles with commit_v_i=0 and stall_reason_i=16'h0030, 3 cycles with 16'h8000, 2 cycles with 16'h0000, then dump -> id4=5, id5=0, id15=3, id17=2, id18=10.
- count_en_i=0 for 7 cycles with commit_v_i=1, then dump -> every entry 0.
- clear_on_dump_p=1, 4 commits, dump_i asserted in the same cycle as a 5th commit -> snapshot id16=4; a second dump after idle cycles shows id16=1.
- ready_i held low for 3 cycles at id 2, then toggled 1/0 -> id_o and count_o stable while stalled, no skipped or duplicated ids, busy_o falls the cycle after the id18 handshake; a dump_i pulse mid-SEND produces no extra dump.
- ctr_width_p=4, 20 commit cycles -> id16=15 (saturated) and id18=15; reset_li pulsed low at id 7 -> v_o=0 and busy_o=0 immediately, and a later dump shows all entries 0.

Source files
------------

// File: rtl/bp_nonsynth_stall_accumulator_if.sv
// Readout port of the stall accumulator: one counter entry per valid/ready handshake.
interface bp_nonsynth_stall_accumulator_if #(
  parameter int ctr_width_p = 32
);
  logic                   v_o;
  logic [4:0]             id_o;
  logic [ctr_width_p-1:0] count_o;
  logic                   ready_i;

  modport master (output v_o, id_o, count_o, input ready_i);
  modport slave  (input v_o, id_o, count_o, output ready_i);
endinterface

// File: rtl/bp_nonsynth_stall_accumulator.sv
// Attributes each non-commit cycle to one stall reason, keeps saturating counters,
// and serializes a snapshot of all counters through a valid/ready readout port.
module bp_nonsynth_stall_accumulator #(
  parameter int ctr_width_p     = 32,
  parameter bit clear_on_dump_p = 1'b1,
  parameter int num_reasons_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_li,
  input  logic                     count_en_i,
  input  logic                     commit_v_i,
  input  logic [num_reasons_p-1:0] stall_reason_i,
  input  logic                     dump_i,
  output logic                     busy_o,
  bp_nonsynth_stall_accumulator_if.master rd
);

  localparam int commit_id_lp   = num_reasons_p;
  localparam int unattr_id_lp   = num_reasons_p + 1;
  localparam int cycles_id_lp   = num_reasons_p + 2;
  localparam int num_entries_lp = num_reasons_p + 3;
  localparam logic [4:0] last_id_lp = 5'(num_entries_lp - 1);

  localparam logic [0:0] idle_s = 1'b0;
  localparam logic [0:0] send_s = 1'b1;

  logic [0:0] state_r;
  logic [4:0] index_r;
  logic [ctr_width_p-1:0] live_r   [num_entries_lp];
  logic [ctr_width_p-1:0] shadow_r [num_entries_lp];
  logic [num_entries_lp-1:0] inc;
  logic [num_reasons_p-1:0] lowest_reason;
  logic take_snap;
  logic handshake;

  // Isolate the lowest set bit: bit0 (freeze) has the highest priority.
  assign lowest_reason = stall_reason_i & (~stall_reason_i + num_reasons_p'(1));

  always_comb begin
    inc = '0;
    if (count_en_i) begin
      inc[cycles_id_lp] = 1'b1;
      if (commit_v_i)
        inc[commit_id_lp] = 1'b1;
      else if (|stall_reason_i)
        inc[num_reasons_p-1:0] = lowest_reason;
      else
        inc[unattr_id_lp] = 1'b1;
    end
  end

  assign take_snap = (state_r == idle_s) && dump_i;
  assign handshake = (state_r == send_s) && rd.ready_i;

  // On a clearing snapshot the live counter restarts at this cycle's increment,
  // so the event seen in the dump cycle lands in the next snapshot only.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int unsigned k = 0; k < num_entries_lp; k++) begin
        live_r[k]   <= '0;
        shadow_r[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < num_entries_lp; k++) begin
        if (take_snap)
          shadow_r[k] <= live_r[k];
        if (take_snap && clear_on_dump_p)
          live_r[k] <= inc[k] ? ctr_width_p'(1) : '0;
        else if (inc[k] && (live_r[k] != '1))
          live_r[k] <= live_r[k] + ctr_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      state_r <= idle_s;
      index_r <= '0;
    end else begin
      case (state_r)
        idle_s: begin
          if (dump_i) begin
            state_r <= send_s;
            index_r <= '0;
          end
        end
        default: begin
          if (handshake) begin
            if (index_r == last_id_lp) begin
              state_r <= idle_s;
              index_r <= '0;
            end else begin
              index_r <= index_r + 5'd1;
            end
          end
        end
      endcase
    end
  end

  assign busy_o     = (state_r == send_s);
  assign rd.v_o     = (state_r == send_s);
  assign rd.id_o    = index_r;
  assign rd.count_o = (state_r == send_s) ? shadow_r[index_r] : '0;

endmodule

// File: tb/tb_bp_nonsynth_stall_accumulator.sv
// Scoreboard bench: stimulus queues the expected dump entries, per-DUT monitors
// pop and compare on every readout handshake.
module tb_bp_nonsynth_stall_accumulator;

  typedef struct {
    int unsigned id;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n, rst4_n;
  logic count_en, commit_v, dump0, dump4;
  logic [15:0] reason;
  logic busy0, busy4;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q4[$];

  bp_nonsynth_stall_accumulator_if #(.ctr_width_p(32)) if0 ();
  bp_nonsynth_stall_accumulator_if #(.ctr_width_p(4))  if4 ();

  bp_nonsynth_stall_accumulator #(
    .ctr_width_p(32), .clear_on_dump_p(1'b1), .num_reasons_p(16)
  ) dut (
    .clk_i(clk), .reset_li(rst_n), .count_en_i(count_en), .commit_v_i(commit_v),
    .stall_reason_i(reason), .dump_i(dump0), .busy_o(busy0), .rd(if0)
  );

  bp_nonsynth_stall_accumulator #(
    .ctr_width_p(4), .clear_on_dump_p(1'b1), .num_reasons_p(16)
  ) dut4 (
    .clk_i(clk), .reset_li(rst4_n), .count_en_i(count_en), .commit_v_i(commit_v),
    .stall_reason_i(reason), .dump_i(dump4), .busy_o(busy4), .rd(if4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 32-bit instance
  logic       hold0 = 1'b0, idle0 = 1'b0;
  logic [4:0] hid0;
  logic [31:0] hcnt0;
  always @(negedge clk) begin
    if (idle0) begin
      chk("busy_fall0", {31'b0, busy0}, 32'd0);
      chk("v_fall0", {31'b0, if0.v_o}, 32'd0);
      idle0 = 1'b0;
    end
    if (rst_n && if0.v_o) begin
      chk("busy_in_send0", {31'b0, busy0}, 32'd1);
      if (hold0) begin
        chk("stall_id0", {27'b0, if0.id_o}, {27'b0, hid0});
        chk("stall_cnt0", if0.count_o, hcnt0);
      end
      if (if0.ready_i) begin
        if (q0.size() == 0) begin
          chk("unexpected_entry0", {27'b0, if0.id_o}, 32'hffff_ffff);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("entry_id0", {27'b0, if0.id_o}, e.id);
          chk($sformatf("entry_cnt0_id%0d", e.id), if0.count_o, e.cnt);
        end
        if (if0.id_o == 5'd18) idle0 = 1'b1;
        hold0 = 1'b0;
      end else begin
        hold0 = 1'b1;
        hid0  = if0.id_o;
        hcnt0 = if0.count_o;
      end
    end else begin
      hold0 = 1'b0;
    end
  end

  // Monitor for the 4-bit instance
  logic idle4 = 1'b0;
  always @(negedge clk) begin
    if (idle4) begin
      chk("busy_fall4", {31'b0, busy4}, 32'd0);
      chk("v_fall4", {31'b0, if4.v_o}, 32'd0);
      idle4 = 1'b0;
    end
    if (rst4_n && if4.v_o && if4.ready_i) begin
      if (q4.size() == 0) begin
        chk("unexpected_entry4", {27'b0, if4.id_o}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("entry_id4", {27'b0, if4.id_o}, e.id);
        chk($sformatf("entry_cnt4_id%0d", e.id), 32'(if4.count_o), e.cnt);
      end
      if (if4.id_o == 5'd18) idle4 = 1'b1;
    end
  end

  // mode 0: ready always high; mode 1: stall at id 2 then toggle, with a stray dump pulse;
  // mode 2: ready high, reset pulsed when id 7 is presented.
  task automatic dump_run(input int sel, input int mode, input logic [31:0] e[19], input int push_n);
    int n;
    logic b;
    for (int k = 0; k < push_n; k++) begin
      exp_t x;
      x.id = k;
      x.cnt = e[k];
      if (sel == 0) q0.push_back(x); else q4.push_back(x);
    end
    if (sel == 0) dump0 = 1'b1; else dump4 = 1'b1;
    tick();
    dump0 = 1'b0;
    dump4 = 1'b0;
    count_en = 1'b0;
    commit_v = 1'b0;
    reason = '0;
    n = 0;
    b = (sel == 0) ? busy0 : busy4;
    chk("busy_after_dump", {31'b0, b}, 32'd1);
    while (b && n < 300) begin
      logic r;
      if (mode == 1) begin
        r = (n < 2) ? 1'b1 : (n < 5) ? 1'b0 : n[0];
        if (sel == 0) dump0 = (n == 3); else dump4 = (n == 3);
      end else begin
        r = 1'b1;
      end
      if (sel == 0) if0.ready_i = r; else if4.ready_i = r;
      tick();
      n++;
      if (mode == 2 && sel == 4 && if4.id_o == 5'd7) begin
        rst4_n = 1'b0;
        #1;
        chk("abort_v", {31'b0, if4.v_o}, 32'd0);
        chk("abort_busy", {31'b0, busy4}, 32'd0);
        chk("abort_id", {27'b0, if4.id_o}, 32'd0);
        chk("abort_cnt", 32'(if4.count_o), 32'd0);
        chk("abort_q_empty", q4.size(), 32'd0);
        tick();
        rst4_n = 1'b1;
        break;
      end
      b = (sel == 0) ? busy0 : busy4;
    end
    dump0 = 1'b0;
    dump4 = 1'b0;
    if0.ready_i = 1'b0;
    if4.ready_i = 1'b0;
    if (mode != 2) chk("dump_timeout", {31'b0, b}, 32'd0);
    if (mode == 0) chk("busy_cycles", n, 32'd19);
    repeat (4) tick();
    b = (sel == 0) ? (busy0 | if0.v_o) : (busy4 | if4.v_o);
    chk("no_extra_dump", {31'b0, b}, 32'd0);
  endtask

  task automatic run_cycles(input int n, input logic en, input logic cv, input logic [15:0] r);
    count_en = en;
    commit_v = cv;
    reason = r;
    repeat (n) tick();
    count_en = 1'b0;
    commit_v = 1'b0;
    reason = '0;
  endtask

  initial begin
    logic [31:0] e[19];
    rst_n = 1'b0;
    rst4_n = 1'b0;
    count_en = 1'b0;
    commit_v = 1'b0;
    reason = '0;
    dump0 = 1'b0;
    dump4 = 1'b0;
    if0.ready_i = 1'b0;
    if4.ready_i = 1'b0;
    repeat (3) tick();
    chk("rst_v", {31'b0, if0.v_o}, 32'd0);
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    chk("rst_id", {27'b0, if0.id_o}, 32'd0);
    chk("rst_cnt", if0.count_o, 32'd0);
    rst_n = 1'b1;
    rst4_n = 1'b1;
    tick();

    // commits outrank a set stall reason
    run_cycles(10, 1'b1, 1'b1, 16'h0010);
    e = '{default: 32'd0};
    e[16] = 32'd10;
    e[18] = 32'd10;
    dump_run(0, 0, e, 19);

    // lowest set bit wins; empty vector is unattributed
    count_en = 1'b1;
    reason = 16'h0030; repeat (5) tick();
    reason = 16'h8000; repeat (3) tick();
    reason = 16'h0000; repeat (2) tick();
    count_en = 1'b0;
    e = '{default: 32'd0};
    e[4] = 32'd5;
    e[15] = 32'd3;
    e[17] = 32'd2;
    e[18] = 32'd10;
    dump_run(0, 0, e, 19);

    // counting disabled
    run_cycles(7, 1'b0, 1'b1, 16'h0000);
    e = '{default: 32'd0};
    dump_run(0, 0, e, 19);

    // dump in the same cycle as a 5th commit
    count_en = 1'b1;
    commit_v = 1'b1;
    repeat (4) tick();
    e = '{default: 32'd0};
    e[16] = 32'd4;
    e[18] = 32'd4;
    dump_run(0, 0, e, 19);
    repeat (3) tick();
    e = '{default: 32'd0};
    e[16] = 32'd1;
    e[18] = 32'd1;
    dump_run(0, 1, e, 19);

    // 4-bit instance: saturation, then reset mid-readout
    rst4_n = 1'b0;
    tick();
    rst4_n = 1'b1;
    tick();
    run_cycles(20, 1'b1, 1'b1, 16'h0000);
    e = '{default: 32'd0};
    e[16] = 32'd15;
    e[18] = 32'd15;
    dump_run(4, 0, e, 19);
    run_cycles(3, 1'b1, 1'b1, 16'h0000);
    e = '{default: 32'd0};
    dump_run(4, 2, e, 7);
    e = '{default: 32'd0};
    dump_run(4, 0, e, 19);

    repeat (3) tick();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
